// File: rtl/lfsr_word_packer.sv
// lfsr_word_packer
//   Collects WIDTH successive serial bits from the LFSR into a parallel word
//   and buffers completed words in a DEPTH-entry FIFO. The words go out on a
//   valid/ready interface.
//
// Ports
//   clk         rising-edge clock shared with the LFSR
//   reset       asynchronous active-high reset, clears all state
//   bit_in      serial random bit
//   bit_en      sample bit_in on this edge
//   clear       synchronous clear of the partial word, the FIFO and overflow
//   word_out    FIFO head word, 0 when empty
//   word_valid  FIFO non-empty
//   word_ready  consumer accepts the head word on this edge
//   count       number of words held in the FIFO
//   full        count == DEPTH
//   overflow    sticky flag, set when a completed word was dropped
module lfsr_word_packer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_in,
    input  logic                       bit_en,
    input  logic                       clear,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned BitW = $clog2(WIDTH);
    localparam int unsigned PtrW = $clog2(DEPTH);

    localparam logic [BitW-1:0] LastBit  = BitW'(WIDTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             empty;
    logic             is_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             mem_we;

    always_comb begin
        // Accumulator with the current bit already included, so a completing
        // edge pushes the whole word including this bit.
        if (MSB_FIRST) begin
            shifted = {acc_q[WIDTH-2:0], bit_in};
        end else begin
            shifted = {bit_in, acc_q[WIDTH-1:1]};
        end

        empty    = (count_q == '0);
        is_full  = (count_q == DepthCnt);
        complete = bit_en && (bit_cnt_q == LastBit);
        pop      = !empty && word_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push     = complete && (!is_full || pop);
        drop     = complete && is_full && !pop;
        mem_we   = push && !clear;
    end

    always_comb begin
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear) begin
            acc_d      = '0;
            bit_cnt_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (bit_en) begin
                acc_d     = shifted;
                bit_cnt_d = complete ? '0 : bit_cnt_q + BitW'(1);
            end
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= shifted;
        end
    end

    // Outputs depend on registers only.
    assign word_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign word_valid = !empty;
    assign count      = count_q;
    assign full       = is_full;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lfsr_word_packer.sv
module tb_lfsr_word_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_en;
    logic       clear;
    logic       word_ready;

    logic [7:0] word_out_m, word_out_l;
    logic       word_valid_m, word_valid_l;
    logic [2:0] count_m, count_l;
    logic       full_m, full_l;
    logic       overflow_m, overflow_l;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lfsr_word_packer #(
        .WIDTH     (8),
        .DEPTH     (4),
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .clear      (clear),
        .word_out   (word_out_m),
        .word_valid (word_valid_m),
        .word_ready (word_ready),
        .count      (count_m),
        .full       (full_m),
        .overflow   (overflow_m)
    );

    lfsr_word_packer #(
        .WIDTH     (8),
        .DEPTH     (4),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .clear      (clear),
        .word_out   (word_out_l),
        .word_valid (word_valid_l),
        .word_ready (word_ready),
        .count      (count_l),
        .full       (full_l),
        .overflow   (overflow_l)
    );

    typedef struct {
        logic [7:0] bits;     // fed bits[7] first
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs set before tick apply at the next rising edge; outputs are read 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        bit_in = 1'b0;
    endtask

    // Sends the first n bits of w, starting at w[7].
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(w[7-i]);
        end
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    logic [7:0] words [5];

    initial begin
        vecs[0] = '{bits: 8'hB2, exp_msb: 8'hB2, exp_lsb: 8'h4D};
        vecs[1] = '{bits: 8'hFF, exp_msb: 8'hFF, exp_lsb: 8'hFF};
        vecs[2] = '{bits: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
        vecs[3] = '{bits: 8'hE8, exp_msb: 8'hE8, exp_lsb: 8'h17};
        vecs[4] = '{bits: 8'h12, exp_msb: 8'h12, exp_lsb: 8'h48};
        vecs[5] = '{bits: 8'h00, exp_msb: 8'h00, exp_lsb: 8'h00};

        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_en     = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        tick();
        tick();
        check("reset word_valid", {31'd0, word_valid_m}, 32'd0);
        check("reset word_out", {24'd0, word_out_m}, 32'd0);
        check("reset count", {29'd0, count_m}, 32'd0);
        check("reset full", {31'd0, full_m}, 32'd0);
        check("reset overflow", {31'd0, overflow_m}, 32'd0);
        reset = 1'b0;
        tick();

        // Single-word assembly in both bit orders, one pop each.
        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].bits, 7);
            check("vec partial valid", {31'd0, word_valid_m}, 32'd0);
            send_bit(vecs[v].bits[0]);
            check("vec valid", {31'd0, word_valid_m}, 32'd1);
            check("vec word msb", {24'd0, word_out_m}, {24'd0, vecs[v].exp_msb});
            check("vec word lsb", {24'd0, word_out_l}, {24'd0, vecs[v].exp_lsb});
            check("vec count", {29'd0, count_m}, 32'd1);
            pop_one();
            check("vec popped valid", {31'd0, word_valid_m}, 32'd0);
            check("vec popped word_out", {24'd0, word_out_m}, 32'd0);
        end

        // Ready while empty is ignored.
        pop_one();
        check("empty pop count", {29'd0, count_m}, 32'd0);

        // Fill to full, then overflow on the fifth word.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        for (int w = 0; w < 4; w++) begin
            send_bits(words[w], 8);
        end
        check("fill full", {31'd0, full_m}, 32'd1);
        check("fill count", {29'd0, count_m}, 32'd4);
        check("fill no overflow", {31'd0, overflow_m}, 32'd0);
        send_bits(words[4], 8);
        check("drop overflow", {31'd0, overflow_m}, 32'd1);
        check("drop count", {29'd0, count_m}, 32'd4);
        for (int w = 0; w < 4; w++) begin
            check("drop order", {24'd0, word_out_m}, {24'd0, words[w]});
            pop_one();
        end
        check("drained count", {29'd0, count_m}, 32'd0);
        check("overflow sticky", {31'd0, overflow_m}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear overflow", {31'd0, overflow_m}, 32'd0);

        // Full FIFO, completing bit and pop on the same edge.
        words[0] = 8'h66; words[1] = 8'h77; words[2] = 8'h88;
        words[3] = 8'h99; words[4] = 8'hAA;
        for (int w = 0; w < 4; w++) begin
            send_bits(words[w], 8);
        end
        send_bits(words[4], 7);
        word_ready = 1'b1;
        send_bit(words[4][0]);
        word_ready = 1'b0;
        check("push+pop full count", {29'd0, count_m}, 32'd4);
        check("push+pop full overflow", {31'd0, overflow_m}, 32'd0);
        for (int w = 1; w < 5; w++) begin
            check("push+pop order", {24'd0, word_out_m}, {24'd0, words[w]});
            pop_one();
        end

        // Clear with bit_en high discards the partial word and the FIFO.
        send_bits(8'h5A, 8);
        send_bits(8'hFF, 3);
        clear  = 1'b1;
        bit_in = 1'b1;
        bit_en = 1'b1;
        tick();
        clear  = 1'b0;
        bit_en = 1'b0;
        check("clear count", {29'd0, count_m}, 32'd0);
        check("clear valid", {31'd0, word_valid_m}, 32'd0);
        send_bits(8'hC3, 7);
        check("after clear partial", {31'd0, word_valid_m}, 32'd0);
        send_bit(1'b1);
        check("after clear word", {24'd0, word_out_m}, 32'h0000_00C3);
        check("after clear count", {29'd0, count_m}, 32'd1);

        // Asynchronous reset mid-word with two words queued.
        send_bits(8'h3E, 8);
        check("pre-reset count", {29'd0, count_m}, 32'd2);
        send_bits(8'hFF, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async reset valid", {31'd0, word_valid_m}, 32'd0);
        check("async reset word_out", {24'd0, word_out_m}, 32'd0);
        check("async reset count", {29'd0, count_m}, 32'd0);
        tick();
        reset = 1'b0;
        send_bits(8'h96, 7);
        check("post-reset partial", {31'd0, word_valid_m}, 32'd0);
        send_bit(1'b0);
        check("post-reset valid", {31'd0, word_valid_m}, 32'd1);
        check("post-reset word", {24'd0, word_out_m}, 32'h0000_0096);
        check("post-reset count", {29'd0, count_m}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
